// File: rtl/corescore_receiver_uart_if.sv
// Consumer-side bus of the UART receiver: received byte with valid/ready
// handshake plus the framing-error and overrun event pulses.
interface corescore_receiver_uart_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;

  // Receiver side: produces data and event pulses, observes ready.
  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_overrun,
    input  i_ready
  );

  // Consumer side: observes data and events, drives ready.
  modport slave (
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_overrun,
    output i_ready
  );
endinterface

// File: rtl/corescore_receiver_uart.sv
// 8N1 UART receiver. The RX pin is double-synchronised; a falling edge on the
// synchronised line starts a frame, and every bit (start, 8 data LSB first,
// stop) is sampled once at mid-bit. Completed bytes are offered over a
// valid/ready handshake; framing errors and overruns are one-cycle pulses.
module corescore_receiver_uart #(
  parameter int unsigned clk_freq_hz = 27000000,
  parameter int unsigned baud_rate   = 115200
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_uart_rx,
  corescore_receiver_uart_if.master  bus
);

  localparam int unsigned CPB  = clk_freq_hz / baud_rate;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = $clog2(CPB) + 1;

  localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] C_CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser and edge-detect history; all idle high.
  logic          r_sync1;
  logic          r_rx_s;
  logic          r_rx_prev;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_overrun;

  state_t        w_state;
  logic [CW-1:0] w_cnt;
  logic [2:0]    w_idx;
  logic [7:0]    w_shift;
  logic [7:0]    w_data;
  logic          w_valid;
  logic          w_frame_err;
  logic          w_overrun;
  logic          w_done;
  logic          w_fall;

  initial begin : g_param_check
    assert (CPB >= 4) else $error("CPB must be at least 4");
  end

  // Two-flop synchroniser on the RX pin, plus one history flop for edge detect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= i_uart_rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_s;

  // State, bit timing, shift register and delivery registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_idx       <= w_idx;
      r_shift     <= w_shift;
      r_data      <= w_data;
      r_valid     <= w_valid;
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
    end
  end

  // Next-state, bit sampling and handshake/delivery decisions.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_idx       = r_idx;
    w_shift     = r_shift;
    w_data      = r_data;
    w_valid     = r_valid;
    w_frame_err = 1'b0;
    w_overrun   = 1'b0;
    w_done      = 1'b0;

    if (r_valid && bus.i_ready) begin
      w_valid = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_cnt   = C_HALF_M1;
          w_state = S_START;
        end
      end

      S_START: begin
        if (r_cnt == '0) begin
          if (!r_rx_s) begin
            w_cnt   = C_CPB_M1;
            w_idx   = '0;
            w_state = S_DATA;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_cnt = r_cnt - C_ONE;
        end
      end

      S_DATA: begin
        if (r_cnt == '0) begin
          w_shift[r_idx] = r_rx_s;
          w_cnt          = C_CPB_M1;
          w_idx          = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state = S_STOP;
          end
        end else begin
          w_cnt = r_cnt - C_ONE;
        end
      end

      S_STOP: begin
        if (r_cnt == '0) begin
          if (r_rx_s) begin
            w_done  = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state     = S_BREAK;
          end
        end else begin
          w_cnt = r_cnt - C_ONE;
        end
      end

      S_BREAK: begin
        if (r_rx_s) begin
          w_state = S_IDLE;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    // A byte completing in the same cycle as a consume replaces the old one.
    if (w_done) begin
      if (!r_valid || bus.i_ready) begin
        w_data  = r_shift;
        w_valid = 1'b1;
      end else begin
        w_overrun = 1'b1;
      end
    end
  end

  assign bus.o_data      = r_data;
  assign bus.o_valid     = r_valid;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_overrun   = r_overrun;

endmodule

// File: tb/tb_corescore_receiver_uart.sv
// Self-checking bench for corescore_receiver_uart at CPB=10: a scoreboard
// queue holds bytes expected at the handshake; event pulses are counted.
module tb_corescore_receiver_uart;

  localparam int BIT = 10;

  logic clk;
  logic rst;
  logic uart_rx;

  corescore_receiver_uart_if bus();

  corescore_receiver_uart #(
    .clk_freq_hz(1000000),
    .baud_rate  (100000)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_uart_rx(uart_rx),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_rise = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  logic prev_v = 1'b0;
  logic [7:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: handshake pops the scoreboard, pulses and valid rises are counted.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid && bus.i_ready) begin
        if (sb_q.size() == 0) begin
          chk("scoreboard_nonempty", sb_q.size(), 1);
        end else begin
          chk("rx_byte", {24'd0, bus.o_data}, {24'd0, sb_q.pop_front()});
        end
      end
      if (bus.o_valid && !prev_v) n_rise++;
      if (bus.o_frame_err) n_ferr++;
      if (bus.o_overrun) n_ovr++;
    end
    prev_v = bus.o_valid;
  end

  task automatic idle(input int cycles);
    uart_rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.i_ready = v;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
    chk(tag, sb_q.size(), 0);
  endtask

  int rise0, ferr0, ovr0;

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    bus.i_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, bus.o_data}, 32'h0);
    chk("reset_valid", bus.o_valid, 0);
    chk("reset_ferr", bus.o_frame_err, 0);
    chk("reset_ovr", bus.o_overrun, 0);
    rst = 1'b0;
    idle(20);

    // Single byte, consumer always ready.
    rise0 = n_rise;
    sb_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_drain("drain_a5");
    idle(5);
    chk("a5_one_valid", n_rise - rise0, 1);
    chk("a5_no_ferr", n_ferr, 0);
    chk("a5_no_ovr", n_ovr, 0);
    chk("a5_valid_low", bus.o_valid, 0);

    // Back-to-back frames with no consumer: second byte is an overrun.
    set_ready(1'b0);
    sb_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(5);
    chk("ovr_data_held", {24'd0, bus.o_data}, 32'h00);
    chk("ovr_valid_held", bus.o_valid, 1);
    chk("ovr_one_pulse", n_ovr, 1);
    set_ready(1'b1);
    wait_drain("drain_00");
    repeat (2) @(negedge clk);
    chk("ovr_valid_falls", bus.o_valid, 0);

    // Stop bit low: one framing error, nothing delivered, then recovery.
    rise0 = n_rise;
    send_frame(8'h3C, 1'b0);
    idle(20);
    chk("ferr_one_pulse", n_ferr, 1);
    chk("ferr_no_valid", n_rise - rise0, 0);
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    wait_drain("drain_11");

    // Short glitch on the idle line is rejected.
    idle(5);
    rise0 = n_rise;
    ferr0 = n_ferr;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(20);
    chk("glitch_no_valid", n_rise - rise0, 0);
    chk("glitch_no_ferr", n_ferr - ferr0, 0);
    sb_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_drain("drain_5a");

    // Line held low for 50 bit-times: exactly one framing error.
    idle(5);
    ferr0 = n_ferr;
    rise0 = n_rise;
    uart_rx = 1'b0;
    repeat (50 * BIT) @(negedge clk);
    idle(20);
    chk("break_one_ferr", n_ferr - ferr0, 1);
    chk("break_no_valid", n_rise - rise0, 0);
    sb_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_drain("drain_81");

    // Reset mid-frame, with an unconsumed byte pending beforehand.
    idle(5);
    set_ready(1'b0);
    send_frame(8'h77, 1'b1);
    idle(5);
    chk("pend_valid", bus.o_valid, 1);
    chk("pend_data", {24'd0, bus.o_data}, 32'h77);
    ovr0 = n_ovr;
    ferr0 = n_ferr;
    rise0 = n_rise;
    uart_rx = 1'b0;                      // start bit of 0xF0
    repeat (BIT) @(negedge clk);
    repeat (4 * BIT) @(negedge clk);     // bits 0..3 are zero
    uart_rx = 1'b1;                      // bits 4..7 and stop are one
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", bus.o_valid, 0);
    chk("rst_mid_data", {24'd0, bus.o_data}, 32'h0);
    chk("rst_mid_ferr", bus.o_frame_err, 0);
    chk("rst_mid_ovr", bus.o_overrun, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(5 * BIT);
    chk("abort_no_valid", n_rise - rise0, 0);
    chk("abort_no_ferr", n_ferr - ferr0, 0);
    chk("abort_no_ovr", n_ovr - ovr0, 0);
    set_ready(1'b1);
    sb_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    wait_drain("drain_c3");
    idle(10);
    chk("final_ovr_total", n_ovr, 1);
    chk("final_queue_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
